// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - register map constants shared by the gpio_port files
//
// Purpose: register offsets relative to the port's BASE address.
// Ports:   none (package).
package gpio_pkg;

  localparam logic [23:0] GPIO_DIR     = 24'd0;
  localparam logic [23:0] GPIO_DATA    = 24'd1;
  localparam logic [23:0] GPIO_RISE_EN = 24'd2;
  localparam logic [23:0] GPIO_FALL_EN = 24'd3;
  localparam logic [23:0] GPIO_PEND    = 24'd4;

endpackage

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - per-pin synchroniser, debounce filter and edge pulses
//
// Purpose: brings one asynchronous pad into the clk domain, accepts a new level
//          only after it has been held DEBOUNCE ce cycles, and pulses on changes.
// Ports:   clk, clk_ce, reset (sync, active-high), pin (raw pad)
//          stable (filtered level), rise / fall (one-cycle pulses, valid on the
//          ce edge where stable changes)
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE = 0
) (
  input  logic clk,
  input  logic clk_ce,
  input  logic reset,
  input  logic pin,
  output logic stable,
  output logic rise,
  output logic fall
);

  // DEBOUNCE of 0 would give a zero-width counter; one bit is the floor.
  localparam int CW    = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam int LIMIT = ((DEBOUNCE > 1) ? DEBOUNCE : 1) - 1;
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    meta_d   = meta_q;
    sync_d   = sync_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (clk_ce) begin
      meta_d = pin;
      sync_d = meta_q;
      if (sync_q != stable_q) begin
        // The cycle that reaches LIMIT is itself the last required hold cycle.
        if (cnt_q == LIMIT_C) begin
          stable_d = sync_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Pulses are combinational so the owner can latch PEND on the same edge
  // that updates stable.
  assign stable = stable_q;
  assign rise   = (stable_d != stable_q) &&  stable_d;
  assign fall   = (stable_d != stable_q) && !stable_d;

endmodule

// File: rtl/gpio_port.sv
// rtl/gpio_port.sv - parametrised GPIO port with edge interrupts
//
// Purpose: per-pin direction, output latch, debounced inputs and rise/fall
//          interrupt pending bits, mapped at BASE..BASE+4.
// Ports:   clk, reset (sync, active-high), clk_ce (global enable)
//          bus_write, bus_address_in[23:0], bus_data_in[7:0] - register writes
//          bus_data_out[7:0] - combinational read data, 0 when not decoded
//          pins_in[WIDTH-1:0] - raw pads; pins_out / pins_oe - latch / drive
//          irq - OR of all pending bits
module gpio_port
  import gpio_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter logic [23:0] BASE     = 24'h2060,
  parameter int          DEBOUNCE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_ce,
  input  logic             bus_write,
  input  logic [23:0]      bus_address_in,
  input  logic [7:0]       bus_data_in,
  output logic [7:0]       bus_data_out,
  input  logic [WIDTH-1:0] pins_in,
  output logic [WIDTH-1:0] pins_out,
  output logic [WIDTH-1:0] pins_oe,
  output logic             irq
);

  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] pend_q, pend_d;

  logic [WIDTH-1:0] stable_v, rise_v, fall_v;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clk    (clk),
      .clk_ce (clk_ce),
      .reset  (reset),
      .pin    (pins_in[i]),
      .stable (stable_v[i]),
      .rise   (rise_v[i]),
      .fall   (fall_v[i])
    );
  end

  logic sel_dir, sel_data, sel_rise, sel_fall, sel_pend, wr;
  logic [WIDTH-1:0] wdat;

  assign sel_dir  = (bus_address_in == BASE + GPIO_DIR);
  assign sel_data = (bus_address_in == BASE + GPIO_DATA);
  assign sel_rise = (bus_address_in == BASE + GPIO_RISE_EN);
  assign sel_fall = (bus_address_in == BASE + GPIO_FALL_EN);
  assign sel_pend = (bus_address_in == BASE + GPIO_PEND);
  assign wr       = clk_ce && bus_write;
  assign wdat     = bus_data_in[WIDTH-1:0];

  always_comb begin
    dir_d     = dir_q;
    data_d    = data_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    if (wr && sel_dir)  dir_d     = wdat;
    if (wr && sel_data) data_d    = wdat;
    if (wr && sel_rise) rise_en_d = wdat;
    if (wr && sel_fall) fall_en_d = wdat;
    // Clear first, then OR in new edges so a same-edge set survives the clear.
    pend_d = pend_q & ~((wr && sel_pend) ? wdat : '0);
    pend_d = pend_d | (rise_v & rise_en_q) | (fall_v & fall_en_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q     <= '0;
      data_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
    end else begin
      dir_q     <= dir_d;
      data_q    <= data_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
    end
  end

  logic [WIDTH-1:0] rd;

  always_comb begin
    rd = '0;
    if (sel_dir)  rd = dir_q;
    if (sel_data) rd = (data_q & dir_q) | (stable_v & ~dir_q);
    if (sel_rise) rd = rise_en_q;
    if (sel_fall) rd = fall_en_q;
    if (sel_pend) rd = pend_q;
    bus_data_out            = '0;
    bus_data_out[WIDTH-1:0] = rd;
  end

  assign pins_out = data_q;
  assign pins_oe  = dir_q;
  assign irq      = |pend_q;

endmodule

// File: doc/gpio_port.md
# gpio_port

Parametrised general-purpose I/O port for the MINX register space, the successor to the fixed two-register direction/data pair now wired directly into the top level. It provides `WIDTH` pins with per-pin direction, output latch, synchronised and debounced inputs, and per-pin rising/falling edge interrupts. Its `bus_data_out` is OR-ed into the register read bus, and `irq` feeds one line of the `irq` block's `irqs` vector.

## Interface
- `WIDTH`, 8 — pin count, 1..8; register bits `[7:WIDTH]` read 0 and ignore writes.
- `BASE`, 24'h2060 — address of the first register; the block decodes `BASE..BASE+4`.
- `DEBOUNCE`, 0 — number of consecutive `clk_ce` cycles an input must hold a new value before it is accepted; values 0 and 1 both mean no filtering.
- `clk` input 1 — the single clock; all state changes on `posedge clk` qualified by `clk_ce`.
- `reset` input 1 — synchronous, active-high.
- `clk_ce` input 1 — clock enable.
- `bus_write` input 1 — write strobe.
- `bus_address_in` input 24 — register address.
- `bus_data_in` input 8 — write data.
- `bus_data_out` output 8 — read data; combinational; 0 when the address is not decoded.
- `pins_in` input WIDTH — raw asynchronous pad inputs.
- `pins_out` output WIDTH — output latch value.
- `pins_oe` output WIDTH — output enable, 1 = drive.
- `irq` output 1 — level interrupt; the OR of all `PEND` bits.

## Operation
Registers, at `BASE` + offset:
- +0 `DIR` — read/write; 1 = output.
- +1 `DATA` — write sets the output latch.
  - Read returns the latch for output pins and the debounced input for input pins.
- +2 `RISE_EN` — read/write; per-pin rising-edge interrupt enable.
- +3 `FALL_EN` — read/write; per-pin falling-edge interrupt enable.
- +4 `PEND` — read returns the pending bits with no side effect; writing 1 to a bit clears it, writing 0 has no effect.

Per-pin input path:
- Two-flop synchroniser produces `sync`.
- A counter of width `$clog2(DEBOUNCE+1)` advances on each ce cycle where `sync != stable`.
- Any ce cycle with `sync == stable` clears the counter.
- When the count reaches `max(DEBOUNCE,1)-1`, `stable <= sync` and the counter clears.

Edge and interrupt rules:
- A `stable` update to 1 is a rise; an update to 0 is a fall.
- `PEND[i]` sets on that same ce edge if the corresponding `RISE_EN[i]`/`FALL_EN[i]` bit is 1.
- Enabling an edge later does not retroactively set `PEND`.
- Edge detection runs for all pins regardless of `DIR`; the input path always observes the pad.
- Simultaneous set and write-1-clear of the same `PEND` bit: set wins.

Outputs and reset:
- `pins_out = DATA latch`, `pins_oe = DIR`.
- Reset clears `DIR`, the `DATA` latch, `RISE_EN`, `FALL_EN`, `PEND`, the synchronisers, `stable` and the counters, so `pins_oe=0`, `pins_out=0`, `irq=0` and `bus_data_out` reads 0 for every register.
- Reset asserted mid-debounce discards the partial count.
- A pad held high through reset produces a rise after release, but it is not latched because the enables are 0.

## Timing
- Register write: takes effect on the `posedge clk` where `clk_ce && bus_write` and the address matches. `pins_out`/`pins_oe` update on that edge and readback reflects it from the next cycle.
- Reads: combinational from the current address; zero latency.
- Input to `stable`: 2 + `max(DEBOUNCE,1)` ce edges after the pad changes, provided the pad is held.
- A glitch shorter than `DEBOUNCE` ce cycles at `sync` produces no `stable` change and no edge.
- `PEND` sets on the same edge as the `stable` change, and `irq` rises in that same cycle.
- With `clk_ce=0`, no state changes; the synchronisers also advance only on ce.

## Structure
- Shared package `gpio_pkg`: register offset constants `GPIO_DIR=0`, `GPIO_DATA=1`, `GPIO_RISE_EN=2`, `GPIO_FALL_EN=3`, `GPIO_PEND=4`.
- Sub-module `gpio_debounce`, one instance per pin through a generate loop:
  - Inputs: `clk`, `clk_ce`, `reset`, `pin`.
  - Outputs: `stable`, `rise`, `fall`.
  - Holds the synchroniser, counter and edge pulses.
- The top level of the block owns the register file, the address decode, the `PEND` logic and the read mux.

## Test plan
- Reset state: assert `reset` for 2 cycles → all five registers read 8'h00, `pins_oe=0`, `irq=0`.
- Output drive: write `DIR=8'h0F`, `DATA=8'hA5`, `pins_in=8'h30` → `pins_oe=8'h0F`, `pins_out=8'hA5`, `DATA` reads 8'h35.
- Debounce, `DEBOUNCE=4`, `RISE_EN=8'h01`:
  - A 3-cycle high pulse on `pins_in[0]` → `PEND=0`, `irq=0`.
  - A held high → `PEND=8'h01` and `irq=1` exactly 6 ce edges after the change.
- Falling edge and clear, `FALL_EN=8'h80`:
  - Drop `pins_in[7]` → `PEND=8'h80`.
  - Write `PEND=8'h7F` → unchanged.
  - Write 8'h80 → `PEND=0`, `irq=0`.
- Set/clear collision: write 1 to `PEND[0]` on the same edge as a qualifying rise on pin 0 → `PEND[0]=1`.
- Parameter sweep, `WIDTH=3`, `BASE=24'h2070`:
  - Write 8'hFF to `DIR` → reads 8'h07.
  - Access at `24'h2060` → `bus_data_out=0` and no state change.
